// File: rtl/alu_issue_queue.sv
// Issue/collect wrapper for the 8-bit ALU: registers one command at a time into the ALU,
// samples its result ALU_LAT cycles later and queues it in a response FIFO.
module alu_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [7:0]                 cmd_a,
  input  logic [7:0]                 cmd_b,
  input  logic [1:0]                 cmd_op,
  output logic [7:0]                 alu_a,
  output logic [7:0]                 alu_b,
  output logic [1:0]                 alu_op,
  output logic                       alu_oe,
  input  logic [7:0]                 alu_y,
  input  logic [4:0]                 alu_flags,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [7:0]                 rsp_y,
  output logic [4:0]                 rsp_flags,
  output logic [1:0]                 rsp_op,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = 2;

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state, next_state;
  logic [TW-1:0]   timer;
  logic            accept, push, pop;
  logic [PW-1:0]   head, tail;
  logic [7:0]      mem_y     [DEPTH];
  logic [4:0]      mem_flags [DEPTH];
  logic [1:0]      mem_op    [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    cmd_ready  = 1'b0;
    alu_oe     = 1'b0;
    busy       = 1'b0;
    accept     = 1'b0;
    push       = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = (count < CW'(DEPTH));
        accept    = cmd_valid && (count < CW'(DEPTH));
        if (accept) next_state = S_WAIT;
      end
      S_WAIT: begin
        alu_oe = 1'b1;
        busy   = 1'b1;
        if (timer == '0) begin
          push       = 1'b1;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Operands are held for the whole WAIT so the ALU sees stable inputs until capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
      timer  <= '0;
    end else begin
      if (accept) begin
        alu_a  <= cmd_a;
        alu_b  <= cmd_b;
        alu_op <= cmd_op;
        timer  <= TW'(ALU_LAT - 1);
      end else if (state == S_WAIT && timer != '0) begin
        timer <= timer - TW'(1);
      end
    end
  end

  assign rsp_valid = (count != '0);
  assign pop       = rsp_valid && rsp_ready;

  // Capture cannot overflow: accept required a free slot and only pops happen meanwhile.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_y[i]     <= '0;
        mem_flags[i] <= '0;
        mem_op[i]    <= '0;
      end
    end else begin
      if (push) begin
        mem_y[tail]     <= alu_y;
        mem_flags[tail] <= alu_flags;
        mem_op[tail]    <= alu_op;
        tail            <= tail + PW'(1);
      end
      if (pop) head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign rsp_y     = mem_y[head];
  assign rsp_flags = mem_flags[head];
  assign rsp_op    = mem_op[head];

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue: adder ALU stub, one DUT at ALU_LAT=1 and one at ALU_LAT=3.
module tb_alu_issue_queue;
  logic       clk = 1'b0;
  logic       rst_n;

  logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, alu_oe, busy;
  logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_y, rsp_y;
  logic [1:0] cmd_op, alu_op, rsp_op;
  logic [4:0] alu_flags, rsp_flags;
  logic [2:0] count;

  logic       c3_valid, c3_ready, r3_valid, r3_ready, oe3, busy3;
  logic [7:0] c3_a, c3_b, a3, b3, y3, r3_y;
  logic [1:0] c3_op, op3, r3_op;
  logic [4:0] f3, r3_flags;
  logic [2:0] count3;

  int n_checks = 0;
  int n_pass   = 0;
  logic [14:0] exp_q[$];
  logic        pend;
  logic [14:0] pend_exp;

  always #5 clk = ~clk;

  function automatic logic [14:0] exp_rsp(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] op);
    logic [8:0] s;
    logic [7:0] y;
    s = {1'b0, a} + {1'b0, b};
    y = s[7:0];
    return {op, ^y, s[8], a > b, a == b, a < b, y};
  endfunction

  // Adder ALU stubs
  always_comb begin
    logic [14:0] r;
    r = exp_rsp(alu_a, alu_b, 2'b00);
    alu_y     = r[7:0];
    alu_flags = r[12:8];
  end
  always_comb begin
    logic [14:0] r;
    r = exp_rsp(a3, b3, 2'b00);
    y3 = r[7:0];
    f3 = r[12:8];
  end

  alu_issue_queue #(.DEPTH(4), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_oe(alu_oe),
    .alu_y(alu_y), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_flags(rsp_flags),
    .rsp_op(rsp_op), .busy(busy), .count(count)
  );

  alu_issue_queue #(.DEPTH(4), .ALU_LAT(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_a(c3_a), .cmd_b(c3_b), .cmd_op(c3_op),
    .alu_a(a3), .alu_b(b3), .alu_op(op3), .alu_oe(oe3),
    .alu_y(y3), .alu_flags(f3),
    .rsp_valid(r3_valid), .rsp_ready(r3_ready), .rsp_y(r3_y), .rsp_flags(r3_flags),
    .rsp_op(r3_op), .busy(busy3), .count(count3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
    for (int k = 0; k < 20 && !cmd_ready; k++) tick;
    check("send_ready", {31'd0, cmd_ready}, 32'd1);
    tick;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle;
    for (int k = 0; k < 10 && busy; k++) tick;
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // Pops every entry in order; also completes a pending held command when it is accepted.
  task automatic drain(input int bound);
    logic take;
    rsp_ready = 1'b1;
    for (int k = 0; k < bound; k++) begin
      if (exp_q.size() == 0 && !pend && count == 3'd0 && !busy) break;
      if (rsp_valid) begin
        if (exp_q.size() == 0) check("drain_extra", 32'd1, 32'd0);
        else check("drain_rsp", {17'd0, rsp_op, rsp_flags, rsp_y}, {17'd0, exp_q.pop_front()});
      end
      take = pend && cmd_ready;
      if (take) exp_q.push_back(pend_exp);
      tick;
      if (take) begin
        cmd_valid = 1'b0;
        pend      = 1'b0;
      end
    end
    rsp_ready = 1'b0;
    check("drain_count", {29'd0, count}, 32'd0);
    check("drain_left", exp_q.size(), 32'd0);
    check("drain_pend", {31'd0, pend}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;
    c3_valid = 1'b0; c3_a = '0; c3_b = '0; c3_op = '0; r3_ready = 1'b0;
    pend = 1'b0; pend_exp = '0;
    #12;
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_alu_oe", {31'd0, alu_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_alu_a", {24'd0, alu_a}, 32'd0);
    check("rst_rsp_y", {24'd0, rsp_y}, 32'd0);
    rst_n = 1'b1;
    tick;

    // 1: single command, one-cycle ALU
    cmd_a = 8'h12; cmd_b = 8'h34; cmd_op = 2'd0; cmd_valid = 1'b1;
    check("t1_ready", {31'd0, cmd_ready}, 32'd1);
    tick;
    cmd_valid = 1'b0;
    check("t1_oe", {31'd0, alu_oe}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_ready_wait", {31'd0, cmd_ready}, 32'd0);
    check("t1_alu_a", {24'd0, alu_a}, 32'h12);
    tick;
    check("t1_oe_off", {31'd0, alu_oe}, 32'd0);
    check("t1_rsp_y", {24'd0, rsp_y}, 32'h46);
    check("t1_rsp_flags", {27'd0, rsp_flags}, 32'b10001);
    check("t1_count", {29'd0, count}, 32'd1);
    check("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);

    // 2: carry case, then pop both
    send(8'hFF, 8'h01, 2'd1);
    wait_idle;
    check("t2_count2", {29'd0, count}, 32'd2);
    rsp_ready = 1'b1;
    check("t2_head0", {24'd0, rsp_y}, 32'h46);
    tick;
    check("t2_count1", {29'd0, count}, 32'd1);
    check("t2_rsp_y", {24'd0, rsp_y}, 32'h00);
    check("t2_rsp_flags", {27'd0, rsp_flags}, 32'b01100);
    check("t2_rsp_op", {30'd0, rsp_op}, 32'd1);
    tick;
    rsp_ready = 1'b0;
    check("t2_count0", {29'd0, count}, 32'd0);
    check("t2_rsp_valid", {31'd0, rsp_valid}, 32'd0);

    // 3: fill the FIFO, fifth command stalls until the consumer drains
    for (int i = 0; i < 4; i++) begin
      send(8'h20 + 8'(i * 17), 8'h30, 2'(i));
      exp_q.push_back(exp_rsp(8'h20 + 8'(i * 17), 8'h30, 2'(i)));
      wait_idle;
    end
    check("t3_full_count", {29'd0, count}, 32'd4);
    cmd_a = 8'hC0; cmd_b = 8'h50; cmd_op = 2'd3; cmd_valid = 1'b1;
    pend = 1'b1; pend_exp = exp_rsp(8'hC0, 8'h50, 2'd3);
    tick; tick;
    check("t3_full_ready", {31'd0, cmd_ready}, 32'd0);
    check("t3_full_busy", {31'd0, busy}, 32'd0);
    check("t3_full_hold", {29'd0, count}, 32'd4);
    drain(60);

    // 4: pop coinciding with capture, pointers wrap past index 3
    send(8'h01, 8'h02, 2'd0); exp_q.push_back(exp_rsp(8'h01, 8'h02, 2'd0)); wait_idle;
    send(8'h80, 8'h80, 2'd1); exp_q.push_back(exp_rsp(8'h80, 8'h80, 2'd1)); wait_idle;
    check("t4_count2", {29'd0, count}, 32'd2);
    send(8'h07, 8'h07, 2'd2);
    exp_q.push_back(exp_rsp(8'h07, 8'h07, 2'd2));
    rsp_ready = 1'b1;
    check("t4_head", {17'd0, rsp_op, rsp_flags, rsp_y}, {17'd0, exp_q.pop_front()});
    tick;
    rsp_ready = 1'b0;
    check("t4_count_same", {29'd0, count}, 32'd2);
    drain(20);

    // 6: ALU_LAT=3 instance
    c3_a = 8'h05; c3_b = 8'h07; c3_op = 2'd2; c3_valid = 1'b1;
    check("l3_ready", {31'd0, c3_ready}, 32'd1);
    tick;
    c3_valid = 1'b0;
    for (int e = 0; e < 3; e++) begin
      check("l3_oe", {31'd0, oe3}, 32'd1);
      check("l3_ready_low", {31'd0, c3_ready}, 32'd0);
      check("l3_count0", {29'd0, count3}, 32'd0);
      tick;
    end
    check("l3_oe_off", {31'd0, oe3}, 32'd0);
    check("l3_count1", {29'd0, count3}, 32'd1);
    check("l3_rsp", {17'd0, r3_op, r3_flags, r3_y}, {17'd0, 2'd2, 5'b00001, 8'h0C});
    check("l3_ready_back", {31'd0, c3_ready}, 32'd1);

    // 5: reset during WAIT discards everything
    send(8'h11, 8'h22, 2'd0); wait_idle;
    send(8'h33, 8'h44, 2'd1);
    check("t5_in_wait", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_oe", {31'd0, alu_oe}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_count", {29'd0, count}, 32'd0);
    check("t5_alu_a", {24'd0, alu_a}, 32'd0);
    check("t5_l3_count", {29'd0, count3}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick; tick; tick;
    check("t5_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check("t5_count_after", {29'd0, count}, 32'd0);
    check("t5_busy_after", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
